// File: rtl/router_pkt_tx_if.sv
// Host/router-side signal bundle for router_pkt_tx: command, byte source,
// router link and status.
interface router_pkt_tx_if;
  logic        start;
  logic [1:0]  dest_addr;
  logic [5:0]  payload_len;
  logic        corrupt_parity;
  logic [7:0]  src_data;
  logic        src_valid;
  logic        src_ready;
  logic [7:0]  data_out;
  logic        pkt_valid;
  logic        busy;
  logic        err;
  logic        tx_busy;
  logic        cmd_err;
  logic        done;
  logic        done_err;
  logic [15:0] pkt_count;

  modport master (
    input  start, dest_addr, payload_len, corrupt_parity, src_data, src_valid,
           busy, err,
    output src_ready, data_out, pkt_valid, tx_busy, cmd_err, done, done_err,
           pkt_count
  );

  modport slave (
    output start, dest_addr, payload_len, corrupt_parity, src_data, src_valid,
           busy, err,
    input  src_ready, data_out, pkt_valid, tx_busy, cmd_err, done, done_err,
           pkt_count
  );
endinterface

// File: rtl/router_pkt_tx.sv
// Router packet source: buffers a payload, then sends header, payload and
// parity with pkt_valid framing, stalling on router busy.
module router_pkt_tx #(
  parameter int unsigned GAP_CYCLES = 3
) (
  input  logic            clk,
  input  logic            rst,
  router_pkt_tx_if.master tx
);
  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_HEADER, S_PAYLOAD, S_PARITY, S_GAP
  } state_t;

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  addr_q, addr_d;
  logic [5:0]  len_q, len_d;
  logic [5:0]  idx_q, idx_d;
  logic        corrupt_q, corrupt_d;
  logic [7:0]  par_q, par_d;
  logic        errf_q, errf_d;
  logic [3:0]  gap_q, gap_d;
  logic [7:0]  mem_q [64];
  logic        mem_we;

  logic        src_ready_q, src_ready_d;
  logic [7:0]  data_q, data_d;
  logic        pkt_valid_q, pkt_valid_d;
  logic        tx_busy_q, tx_busy_d;
  logic        cmd_err_q, cmd_err_d;
  logic        done_q, done_d;
  logic        done_err_q, done_err_d;
  logic [15:0] cnt_q, cnt_d;

  logic [5:0]  last_idx;
  logic [7:0]  header;

  assign last_idx = len_q - 6'd1;
  assign header   = {len_q, addr_q};

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    idx_d       = idx_q;
    corrupt_d   = corrupt_q;
    par_d       = par_q;
    errf_d      = errf_q;
    gap_d       = gap_q;
    mem_we      = 1'b0;
    src_ready_d = src_ready_q;
    data_d      = data_q;
    pkt_valid_d = pkt_valid_q;
    cmd_err_d   = 1'b0;
    done_d      = 1'b0;
    done_err_d  = 1'b0;
    cnt_d       = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (tx.start) begin
          if (tx.dest_addr != 2'd3 && tx.payload_len != 6'd0) begin
            addr_d      = tx.dest_addr;
            len_d       = tx.payload_len;
            corrupt_d   = tx.corrupt_parity;
            idx_d       = '0;
            par_d       = '0;
            errf_d      = 1'b0;
            src_ready_d = 1'b1;
            state_d     = S_FILL;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      end
      S_FILL: begin
        if (tx.src_valid) begin
          mem_we = 1'b1;
          par_d  = par_q ^ tx.src_data;
          if (idx_q == last_idx) begin
            // Header folds into parity here so it is complete before PAYLOAD.
            par_d       = par_q ^ tx.src_data ^ header;
            idx_d       = '0;
            src_ready_d = 1'b0;
            data_d      = header;
            pkt_valid_d = 1'b1;
            state_d     = S_HEADER;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      S_HEADER: begin
        if (!tx.busy) begin
          data_d  = mem_q[idx_q];
          state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (!tx.busy) begin
          if (idx_q == last_idx) begin
            data_d      = corrupt_q ? ~par_q : par_q;
            pkt_valid_d = 1'b0;
            state_d     = S_PARITY;
          end else begin
            idx_d  = idx_q + 6'd1;
            data_d = mem_q[6'(idx_q + 6'd1)];
          end
        end
      end
      S_PARITY: begin
        errf_d = errf_q | tx.err;
        if (!tx.busy) begin
          data_d  = '0;
          gap_d   = '0;
          state_d = S_GAP;
          if (GAP_LAST == 4'd0) begin
            done_d     = 1'b1;
            done_err_d = errf_q | tx.err;
            cnt_d      = cnt_q + 16'd1;
          end
        end
      end
      S_GAP: begin
        errf_d = errf_q | tx.err;
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 4'd1;
          // done is registered so it lands on the final gap cycle itself.
          if (gap_q + 4'd1 == GAP_LAST) begin
            done_d     = 1'b1;
            done_err_d = errf_q | tx.err;
            cnt_d      = cnt_q + 16'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    tx_busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx_q] <= tx.src_data;
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      corrupt_q   <= 1'b0;
      par_q       <= '0;
      errf_q      <= 1'b0;
      gap_q       <= '0;
      src_ready_q <= 1'b0;
      data_q      <= '0;
      pkt_valid_q <= 1'b0;
      tx_busy_q   <= 1'b0;
      cmd_err_q   <= 1'b0;
      done_q      <= 1'b0;
      done_err_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      corrupt_q   <= corrupt_d;
      par_q       <= par_d;
      errf_q      <= errf_d;
      gap_q       <= gap_d;
      src_ready_q <= src_ready_d;
      data_q      <= data_d;
      pkt_valid_q <= pkt_valid_d;
      tx_busy_q   <= tx_busy_d;
      cmd_err_q   <= cmd_err_d;
      done_q      <= done_d;
      done_err_q  <= done_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign tx.src_ready = src_ready_q;
  assign tx.data_out  = data_q;
  assign tx.pkt_valid = pkt_valid_q;
  assign tx.tx_busy   = tx_busy_q;
  assign tx.cmd_err   = cmd_err_q;
  assign tx.done      = done_q;
  assign tx.done_err  = done_err_q;
  assign tx.pkt_count = cnt_q;
endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: table of packets plus hand sequences for
// source gaps, illegal commands, full-length payload and mid-packet reset.
module tb_router_pkt_tx;
  localparam int GAP = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  router_pkt_tx_if bus ();
  router_pkt_tx #(.GAP_CYCLES(GAP)) dut (.clk(clk), .rst(rst), .tx(bus));

  typedef struct {
    logic [1:0]  d;
    logic [5:0]  n;
    logic        c;
    logic [31:0] pl;      // payload byte i at pl[8*i +: 8]
    int          hstall;  // busy cycles while header shown
    int          sidx;    // payload index to stall on (-1 none)
    int          scnt;
    int          errg;    // gap cycle index with err=1 (-1 none)
    logic [7:0]  hdr;
    logic [7:0]  par;
    logic        derr;
  } vec_t;

  vec_t       vecs [5];
  logic [7:0] pl_buf [64];
  int         checks = 0;
  int         failures = 0;
  int         exp_count = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_idle_zero(input string nm);
    chk({nm, "_data"},  32'(bus.data_out), 32'h0);
    chk({nm, "_pv"},    32'(bus.pkt_valid), 32'h0);
    chk({nm, "_rdy"},   32'(bus.src_ready), 32'h0);
    chk({nm, "_busy"},  32'(bus.tx_busy), 32'h0);
    chk({nm, "_cerr"},  32'(bus.cmd_err), 32'h0);
    chk({nm, "_done"},  32'(bus.done), 32'h0);
    chk({nm, "_derr"},  32'(bus.done_err), 32'h0);
    chk({nm, "_count"}, 32'(bus.pkt_count), 32'h0);
  endtask

  task automatic issue(input logic [1:0] d, input logic [5:0] n, input logic c);
    bus.start = 1'b1; bus.dest_addr = d; bus.payload_len = n; bus.corrupt_parity = c;
    tick();
    bus.start = 1'b0; bus.corrupt_parity = 1'b0;
    chk("fill_rdy", 32'(bus.src_ready), 32'h1);
    chk("fill_busy", 32'(bus.tx_busy), 32'h1);
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      bus.src_valid = 1'b1; bus.src_data = pl_buf[i];
      tick();
    end
    bus.src_valid = 1'b0;
  endtask

  task automatic drain(input logic [7:0] hdr, input logic [7:0] par, input int n,
                       input int hstall, input int sidx, input int scnt,
                       input int errg, input logic derr);
    chk("hdr", 32'(bus.data_out), 32'(hdr));
    chk("hdr_pv", 32'(bus.pkt_valid), 32'h1);
    chk("hdr_rdy", 32'(bus.src_ready), 32'h0);
    bus.busy = 1'b1;
    for (int k = 0; k < hstall; k++) begin
      tick();
      chk("hdr_hold", 32'(bus.data_out), 32'(hdr));
      chk("hdr_hold_pv", 32'(bus.pkt_valid), 32'h1);
    end
    bus.busy = 1'b0;
    tick();
    for (int i = 0; i < n; i++) begin
      chk("payload", 32'(bus.data_out), 32'(pl_buf[i]));
      chk("payload_pv", 32'(bus.pkt_valid), 32'h1);
      if (i == sidx) begin
        bus.busy = 1'b1;
        for (int k = 0; k < scnt; k++) begin
          tick();
          chk("payload_hold", 32'(bus.data_out), 32'(pl_buf[i]));
          chk("payload_hold_pv", 32'(bus.pkt_valid), 32'h1);
        end
        bus.busy = 1'b0;
      end
      tick();
    end
    chk("parity", 32'(bus.data_out), 32'(par));
    chk("parity_pv", 32'(bus.pkt_valid), 32'h0);
    tick();
    for (int g = 0; g < GAP; g++) begin
      chk("gap_data", 32'(bus.data_out), 32'h0);
      chk("gap_pv", 32'(bus.pkt_valid), 32'h0);
      chk("gap_busy", 32'(bus.tx_busy), 32'h1);
      chk("gap_done", 32'(bus.done), 32'(g == GAP - 1));
      if (g == GAP - 1) begin
        exp_count++;
        chk("done_err", 32'(bus.done_err), 32'(derr));
        chk("pkt_count", 32'(bus.pkt_count), 32'(exp_count));
      end
      bus.err = (g == errg);
      tick();
      bus.err = 1'b0;
    end
    chk("post_busy", 32'(bus.tx_busy), 32'h0);
    chk("post_done", 32'(bus.done), 32'h0);
  endtask

  task automatic run_vec(input vec_t v);
    for (int i = 0; i < 4; i++) pl_buf[i] = v.pl[8*i +: 8];
    issue(v.d, v.n, v.c);
    fill(int'(v.n));
    drain(v.hdr, v.par, int'(v.n), v.hstall, v.sidx, v.scnt, v.errg, v.derr);
  endtask

  initial begin
    bus.start = 1'b0; bus.dest_addr = '0; bus.payload_len = '0;
    bus.corrupt_parity = 1'b0; bus.src_data = '0; bus.src_valid = 1'b0;
    bus.busy = 1'b0; bus.err = 1'b0;

    vecs[0] = '{2'd1, 6'd4, 1'b0, 32'hD4C3B2A1, 0, -1, 0, -1, 8'h11, 8'h15, 1'b0};
    vecs[1] = '{2'd1, 6'd4, 1'b0, 32'hD4C3B2A1, 2,  2, 3, -1, 8'h11, 8'h15, 1'b0};
    vecs[2] = '{2'd2, 6'd1, 1'b1, 32'h00000000, 0, -1, 0,  0, 8'h06, 8'hF9, 1'b1};
    vecs[3] = '{2'd0, 6'd2, 1'b0, 32'h00000FFF, 0, -1, 0, -1, 8'h08, 8'hF8, 1'b0};
    vecs[4] = '{2'd2, 6'd3, 1'b0, 32'h00563412, 1,  0, 1,  1, 8'h0E, 8'h7E, 1'b1};

    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk_idle_zero("reset");

    for (int v = 0; v < 5; v++) run_vec(vecs[v]);

    // Source gaps, with a stray start during FILL that must be ignored.
    pl_buf[0] = 8'h5A; pl_buf[1] = 8'hA5; pl_buf[2] = 8'h3C;
    issue(2'd0, 6'd3, 1'b0);
    for (int s = 0; s < 5; s++) begin
      bus.src_valid = (s % 2 == 0);
      bus.src_data  = (s % 2 == 0) ? pl_buf[s / 2] : 8'hEE;
      bus.start = (s == 1); bus.dest_addr = 2'd2; bus.payload_len = 6'd5;
      tick();
      bus.start = 1'b0;
      if (s < 4) begin
        chk("gapfill_rdy", 32'(bus.src_ready), 32'h1);
        chk("gapfill_pv", 32'(bus.pkt_valid), 32'h0);
      end
    end
    bus.src_valid = 1'b0;
    drain(8'h0C, 8'hCF, 3, 0, -1, 0, -1, 1'b0);

    // Illegal commands.
    bus.start = 1'b1; bus.dest_addr = 2'd3; bus.payload_len = 6'd4;
    tick();
    bus.start = 1'b0;
    chk("ill_addr_cerr", 32'(bus.cmd_err), 32'h1);
    chk("ill_addr_busy", 32'(bus.tx_busy), 32'h0);
    tick();
    chk("ill_addr_pulse", 32'(bus.cmd_err), 32'h0);
    bus.start = 1'b1; bus.dest_addr = 2'd1; bus.payload_len = 6'd0;
    tick();
    bus.start = 1'b0;
    chk("ill_len_cerr", 32'(bus.cmd_err), 32'h1);
    chk("ill_len_busy", 32'(bus.tx_busy), 32'h0);
    chk("ill_len_pv", 32'(bus.pkt_valid), 32'h0);
    tick();
    chk("ill_len_pulse", 32'(bus.cmd_err), 32'h0);
    chk("ill_len_idle", 32'(bus.tx_busy), 32'h0);

    // Full 63-byte payload: XOR of 0..62 is 0x3F, header 0xFD.
    for (int i = 0; i < 63; i++) pl_buf[i] = 8'(i);
    issue(2'd1, 6'd63, 1'b0);
    fill(63);
    drain(8'hFD, 8'hC2, 63, 0, -1, 0, -1, 1'b0);

    // Reset during the second payload byte.
    pl_buf[0] = 8'hA1; pl_buf[1] = 8'hB2; pl_buf[2] = 8'hC3; pl_buf[3] = 8'hD4;
    issue(2'd1, 6'd4, 1'b0);
    fill(4);
    chk("rst_hdr", 32'(bus.data_out), 32'h11);
    tick();
    chk("rst_b0", 32'(bus.data_out), 32'hA1);
    tick();
    chk("rst_b1", 32'(bus.data_out), 32'hB2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_count = 0;
    chk_idle_zero("midrst");
    tick();
    chk("midrst_stay_idle", 32'(bus.tx_busy), 32'h0);
    run_vec(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/router_pkt_tx.md
Name: router_pkt_tx

Overview:
Packet source that drives the input side of the 1x3 router.
- Accepts a transmit command (destination, length) and buffers the payload bytes from a local byte stream.
- Emits the router packet format: header, payload, then parity byte, with pkt_valid framing and stall on router busy.
- Used as the traffic generator and host-side transmitter in front of the router top level.

Parameters:
GAP_CYCLES, 3, idle cycles after parity before done/next packet; router err is sampled during this window; legal range 1..15.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  command strobe, sampled only in IDLE
dest_addr  input  2  destination port 0..2; value 3 is illegal
payload_len  input  6  payload byte count 1..63; 0 is illegal
corrupt_parity  input  1  sampled with start; inverts the transmitted parity byte (error injection)
src_data  input  8  payload byte from local source
src_valid  input  1  src_data valid
src_ready  output  1  block accepts src_data (FILL state)
data_out  output  8  to router data_in
pkt_valid  output  1  to router pkt_valid
busy  input  1  from router busy
err  input  1  from router err
tx_busy  output  1  high in every state except IDLE
cmd_err  output  1  one-cycle pulse: illegal command rejected
done  output  1  one-cycle pulse at end of GAP
done_err  output  1  valid with done: err seen during PARITY/GAP
pkt_count  output  16  packets completed, wraps at 0xFFFF->0

Behaviour:
- Reset (rst=1 at edge): state IDLE. All outputs 0: data_out, pkt_valid, src_ready, tx_busy, cmd_err, done, done_err, pkt_count. Buffer contents are don't-care. Reset mid-packet aborts immediately with no parity sent, and pkt_count is cleared.
- States: IDLE, FILL, HEADER, PAYLOAD, PARITY, GAP.
- IDLE:
  - start=1 with dest_addr<=2 and payload_len!=0: latch addr, len and corrupt flag; clear the byte index and the parity accumulator; go to FILL.
  - Illegal command: cmd_err pulses the next cycle and the state stays IDLE.
  - start outside IDLE is ignored.
- FILL:
  - src_ready=1.
  - Each edge with src_valid=1 writes src_data to buffer[idx], XORs it into parity, and increments idx.
  - When the byte for idx==len-1 is written: src_ready drops the next cycle, idx is cleared, and the state goes to HEADER.
- HEADER:
  - data_out={len[5:0],addr[1:0]}; pkt_valid=1. The header is XORed into parity on entry.
  - The byte is consumed at an edge where busy=0, then go to PAYLOAD.
  - While busy=1, data_out and pkt_valid hold.
- PAYLOAD:
  - data_out=buffer[idx]; pkt_valid=1.
  - Each edge with busy=0 increments idx. Consuming idx==len-1 goes to PARITY.
  - busy=1 holds the current byte. pkt_valid never drops mid-payload.
- PARITY:
  - pkt_valid=0; data_out=parity, or ~parity if the corrupt flag is set.
  - Consumed at an edge with busy=0, then go to GAP.
- GAP:
  - data_out=0, pkt_valid=0.
  - Counts GAP_CYCLES cycles. err=1 on any cycle in PARITY or GAP sets the sticky err flag.
  - On the last gap cycle: done=1, done_err=flag, pkt_count+=1, state goes to IDLE. tx_busy drops the cycle after done.
- Parity = XOR of the header and all payload bytes, 8 bits.
- Buffer: 64x8, single write port (FILL) and single read port (PAYLOAD).
- Minimum latency: start to first header cycle = len+1 cycles with src_valid held high.

Test Plan:
- Basic: start, addr=1, len=4, payload A1,B2,C3,D4, busy=0 -> data_out sequence 0x11,A1,B2,C3,D4 with pkt_valid=1, then 0x15 with pkt_valid=0; done 3 cycles later; pkt_count=1.
- Stall: same packet, busy=1 for 2 cycles after header and 3 cycles on byte C3 -> each byte held stable with pkt_valid=1 until busy=0; same byte order and parity 0x15.
- Source gaps: len=3 with src_valid toggled 1,0,1,0,1 -> exactly 3 bytes captured; HEADER entered the cycle after the third accepted byte.
- Illegal: start with addr=3, then start with len=0 -> cmd_err pulses once for each; tx_busy stays 0; no pkt_valid.
- Error injection: addr=2, len=1, payload 0x00, corrupt_parity=1 -> header 0x06, parity 0xF9; err driven high 1 cycle into GAP -> done_err=1 with done.
- Reset mid-payload: rst=1 during the 2nd payload byte -> next cycle all outputs 0, state IDLE; the next packet transmits correctly.
